multi_edge_counter: RTL and testbench
=====================================

// Module: multi_edge_counter
// PURPOSE
//  CHANNELS-wide edge detector and event counter, the parametrised successor of
//  the single-bit edge detector and counters in the shared library.
//  Synchronises async inputs, detects rising/falling/both edges per a run-time
//  mode, and counts events per channel with wrap or saturate and sticky overflow.
//  Atomic snapshot of all counts for a slow reader (SPI/UART status path).
// PARAMETERS
//  CHANNELS     4  number of independent input channels (>=1)
//  WIDTH        8  bits per channel counter (>=2)
//  SYNC_STAGES  2  synchroniser flops per input (>=2)
//  SATURATE     0  0: counter wraps max->0; 1: counter holds at max
// PORTS
//  clock       in   1                single clock, all state on posedge
//  reset_n     in   1                asynchronous, active-low reset
//  signal      in   CHANNELS         async inputs, bit i = channel i
//  mode        in   2                00 rising, 01 falling, 10 both, 11 none
//  enable      in   1                1: detected edges increment counters
//  clear       in   CHANNELS         sync per-channel clear of count+overflow
//  snap        in   1                pulse: capture all counts
//  edge_seen   out  CHANNELS         1-cycle pulse per detected edge
//  count       out  CHANNELS*WIDTH   live counts, ch i at [i*WIDTH +: WIDTH]
//  overflow    out  CHANNELS         sticky, set when ch i passes max
//  snap_count  out  CHANNELS*WIDTH   counts captured by last snap
//  snap_valid  out  1                1-cycle pulse: snap_count updated
// BEHAVIOUR
//  - Reset (reset_n=0, any time, incl. mid-count): sync chains, prev, edge_seen,
//    count, overflow, snap_count, snap_valid all 0 immediately; no clock needed.
//  - Sync: sync[0] <= signal; sync[j] <= sync[j-1]; s = sync[SYNC_STAGES-1];
//    prev <= s each cycle. rise = s & ~prev; fall = ~s & prev.
//  - det = mode 00:rise, 01:fall, 10:rise|fall, 11:0. Mode is sampled
//    combinationally; a change applies to the next evaluated cycle, no buffering.
//  - Latency: input change sampled at edge k -> edge_seen high in the cycle after
//    edge k+SYNC_STAGES, exactly one cycle; count updated at that same edge.
//  - Pulses shorter than one clock may be missed; multiple-cycle-apart toggles
//    are each detected. Input high at reset release yields one rising edge.
//  - edge_seen reflects det regardless of enable and clear.
//  - Counter ch i, per edge, priority: clear[i] > (enable & det[i]) > hold.
//    clear[i]: count=0, overflow=0 (clear wins over a simultaneous edge).
//    Increment at count==2^WIDTH-1: SATURATE=0 -> 0, SATURATE=1 -> hold max;
//    both set overflow[i], which stays 1 until clear[i] or reset.
//  - Snap: at edge with snap=1, snap_count <= current count register (the value
//    before any increment/clear on that same edge); snap_valid=1 next cycle only.
//    Back-to-back snap: every cycle recaptures, snap_valid stays high.
//  - Channels fully independent; no cross-channel arbitration.
// TESTING
//  1 reset_n=0 mid-count with signal toggling -> all outputs 0 asynchronously;
//    release with signal=0 -> no edge_seen, count stays 0.
//  2 CH=4,W=8,mode=00,enable=1, ch0 toggles 0->1->0 x3 -> edge_seen[0] 3 pulses,
//    each 3 edges after input change (SYNC_STAGES=2); count0=3, others 0.
//  3 mode=10 same stimulus -> 6 pulses, count0=6; mode=11 -> none, count holds;
//    enable=0, mode=00 -> edge_seen pulses, count unchanged.
//  4 W=4,SATURATE=0: 17 rising edges -> count=1, overflow=1; SATURATE=1:
//    17 edges -> count=15, overflow=1; clear[0] -> count=0, overflow=0.
//  5 clear[1] asserted the same edge edge_seen[1] fires -> count1=0, pulse seen.
//  6 count0=5, snap on same edge as an increment -> snap_count0=5, count0=6,
//    snap_valid high exactly one cycle later.

Source files
------------

// File: rtl/multi_edge_counter.sv
// Multi-channel synchronised edge detector with per-channel event counters,
// sticky overflow and an atomic snapshot of all counts.
module multi_edge_counter #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          SATURATE    = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       signal,
  input  logic [1:0]                mode,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       clear,
  input  logic                      snap,
  output logic [CHANNELS-1:0]       edge_seen,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS*WIDTH-1:0] snap_count,
  output logic                      snap_valid
);

  localparam logic [WIDTH-1:0] CountMax = '1;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  prev_q;
  logic [CHANNELS-1:0]                  sync_out;
  logic [CHANNELS-1:0]                  rise;
  logic [CHANNELS-1:0]                  fall;
  logic [CHANNELS-1:0]                  det;
  logic [CHANNELS-1:0]                  edge_seen_q;
  logic [CHANNELS-1:0][WIDTH-1:0]       count_q;
  logic [CHANNELS-1:0][WIDTH-1:0]       count_d;
  logic [CHANNELS-1:0]                  overflow_q;
  logic [CHANNELS-1:0]                  overflow_d;
  logic [CHANNELS-1:0][WIDTH-1:0]       snap_count_q;
  logic                                 snap_valid_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Mode is applied combinationally so a change takes effect on the very next edge.
  always_comb begin
    rise = sync_out & ~prev_q;
    fall = ~sync_out & prev_q;
    case (mode)
      2'b00:   det = rise;
      2'b01:   det = fall;
      2'b10:   det = rise | fall;
      default: det = '0;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clear[i]) begin
        count_d[i]    = '0;
        overflow_d[i] = 1'b0;
      end else if (enable && det[i]) begin
        if (count_q[i] == CountMax) begin
          overflow_d[i] = 1'b1;
          count_d[i]    = SATURATE ? CountMax : '0;
        end else begin
          count_d[i] = count_q[i] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      prev_q       <= '0;
      edge_seen_q  <= '0;
      count_q      <= '0;
      overflow_q   <= '0;
      snap_count_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], signal};
      prev_q      <= sync_out;
      edge_seen_q <= det;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      // Snapshot takes the pre-update count so it is coherent across channels.
      if (snap) begin
        snap_count_q <= count_q;
      end
      snap_valid_q <= snap;
    end
  end

  assign edge_seen  = edge_seen_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign snap_count = snap_count_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_multi_edge_counter.sv
// Bench for multi_edge_counter: three configurations (W8 wrap, W4 wrap, W4 saturate)
// driven by shared stimulus and checked against a history-based reference model.
module tb_multi_edge_counter;

  localparam int SYNC = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  signal;
  logic [1:0]  mode;
  logic        enable;
  logic [3:0]  clear;
  logic        snap;

  logic [3:0]  es_a, es_b, es_c;
  logic [31:0] cnt_a, snc_a;
  logic [15:0] cnt_b, snc_b, cnt_c, snc_c;
  logic [3:0]  ovf_a, ovf_b, ovf_c;
  logic        sv_a, sv_b, sv_c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  multi_edge_counter #(.CHANNELS(4), .WIDTH(8), .SYNC_STAGES(SYNC), .SATURATE(1'b0)) u_a (
    .clock(clock), .reset_n(reset_n), .signal(signal), .mode(mode), .enable(enable),
    .clear(clear), .snap(snap), .edge_seen(es_a), .count(cnt_a), .overflow(ovf_a),
    .snap_count(snc_a), .snap_valid(sv_a)
  );
  multi_edge_counter #(.CHANNELS(4), .WIDTH(4), .SYNC_STAGES(SYNC), .SATURATE(1'b0)) u_b (
    .clock(clock), .reset_n(reset_n), .signal(signal), .mode(mode), .enable(enable),
    .clear(clear), .snap(snap), .edge_seen(es_b), .count(cnt_b), .overflow(ovf_b),
    .snap_count(snc_b), .snap_valid(sv_b)
  );
  multi_edge_counter #(.CHANNELS(4), .WIDTH(4), .SYNC_STAGES(SYNC), .SATURATE(1'b1)) u_c (
    .clock(clock), .reset_n(reset_n), .signal(signal), .mode(mode), .enable(enable),
    .clear(clear), .snap(snap), .edge_seen(es_c), .count(cnt_c), .overflow(ovf_c),
    .snap_count(snc_c), .snap_valid(sv_c)
  );

  // Reference model: per-cycle sample history plus plain integer counters.
  logic [3:0] hist[$];
  int         m_cnt[3][4];
  int         m_snap[3][4];
  bit         m_ovf[3][4];
  logic [3:0] m_es;
  bit         m_sv;

  function automatic int max_of(int d);
    return (d == 0) ? 255 : 15;
  endfunction

  function automatic logic [31:0] get_cnt(int d, int ch);
    case (d)
      0:       return 32'(cnt_a[ch*8 +: 8]);
      1:       return 32'(cnt_b[ch*4 +: 4]);
      default: return 32'(cnt_c[ch*4 +: 4]);
    endcase
  endfunction

  function automatic logic [31:0] get_snap(int d, int ch);
    case (d)
      0:       return 32'(snc_a[ch*8 +: 8]);
      1:       return 32'(snc_b[ch*4 +: 4]);
      default: return 32'(snc_c[ch*4 +: 4]);
    endcase
  endfunction

  function automatic logic [31:0] get_ovf(int d, int ch);
    case (d)
      0:       return 32'(ovf_a[ch]);
      1:       return 32'(ovf_b[ch]);
      default: return 32'(ovf_c[ch]);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back(4'b0000);
    for (int d = 0; d < 3; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_cnt[d][ch]  = 0;
        m_snap[d][ch] = 0;
        m_ovf[d][ch]  = 1'b0;
      end
    end
    m_es = 4'b0000;
    m_sv = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] s, p, det;
    int nxt;
    if (!reset_n) return;
    // The synchronised value seen at this edge is the sample taken SYNC edges ago.
    s = hist[hist.size()-SYNC];
    p = hist[hist.size()-SYNC-1];
    case (mode)
      2'd0:    det = s & ~p;
      2'd1:    det = ~s & p;
      2'd2:    det = s ^ p;
      default: det = 4'b0000;
    endcase
    for (int d = 0; d < 3; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (snap) m_snap[d][ch] = m_cnt[d][ch];
        if (clear[ch]) begin
          m_cnt[d][ch] = 0;
          m_ovf[d][ch] = 1'b0;
        end else if (enable && det[ch]) begin
          nxt = m_cnt[d][ch] + 1;
          if (nxt > max_of(d)) begin
            m_ovf[d][ch] = 1'b1;
            nxt = (d == 2) ? max_of(d) : nxt % (max_of(d) + 1);
          end
          m_cnt[d][ch] = nxt;
        end
      end
    end
    m_es = det;
    m_sv = snap;
    hist.push_back(signal);
    if (hist.size() > SYNC + 2) void'(hist.pop_front());
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        chk($sformatf("d%0d_count%0d", d, ch), get_cnt(d, ch), 32'(m_cnt[d][ch]));
        chk($sformatf("d%0d_ovf%0d", d, ch), get_ovf(d, ch), 32'(m_ovf[d][ch]));
        chk($sformatf("d%0d_snap%0d", d, ch), get_snap(d, ch), 32'(m_snap[d][ch]));
      end
    end
    chk("edge_seen_a", 32'(es_a), 32'(m_es));
    chk("edge_seen_b", 32'(es_b), 32'(m_es));
    chk("edge_seen_c", 32'(es_c), 32'(m_es));
    chk("snap_valid_a", 32'(sv_a), 32'(m_sv));
    chk("snap_valid_b", 32'(sv_b), 32'(m_sv));
    chk("snap_valid_c", 32'(sv_c), 32'(m_sv));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    logic       lvl;
    logic [1:0] md;
    logic       en;
    int         pulses;
    int         cnt;
  } vec_t;

  vec_t tbl[18];
  int   pulses;

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 1, 1};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 0, 1};
    tbl[2]  = '{1'b1, 2'd0, 1'b1, 1, 2};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 0, 2};
    tbl[4]  = '{1'b1, 2'd0, 1'b1, 1, 3};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 0, 3};
    tbl[6]  = '{1'b1, 2'd2, 1'b1, 1, 4};
    tbl[7]  = '{1'b0, 2'd2, 1'b1, 1, 5};
    tbl[8]  = '{1'b1, 2'd2, 1'b1, 1, 6};
    tbl[9]  = '{1'b0, 2'd2, 1'b1, 1, 7};
    tbl[10] = '{1'b1, 2'd3, 1'b1, 0, 7};
    tbl[11] = '{1'b0, 2'd3, 1'b1, 0, 7};
    tbl[12] = '{1'b1, 2'd1, 1'b1, 0, 7};
    tbl[13] = '{1'b0, 2'd1, 1'b1, 1, 8};
    tbl[14] = '{1'b1, 2'd0, 1'b0, 1, 8};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 0, 8};
    tbl[16] = '{1'b1, 2'd1, 1'b0, 0, 8};
    tbl[17] = '{1'b0, 2'd1, 1'b0, 1, 8};

    reset_n = 1'b0;
    signal  = 4'h0;
    mode    = 2'd0;
    enable  = 1'b1;
    clear   = 4'h0;
    snap    = 1'b0;
    model_reset();
    #12;
    check_all();
    reset_n = 1'b1;
    step();

    // Level changes on ch0, each held four cycles to let the edge through.
    for (int v = 0; v < 18; v++) begin
      signal[0] = tbl[v].lvl;
      mode      = tbl[v].md;
      enable    = tbl[v].en;
      pulses    = 0;
      for (int c = 0; c < 4; c++) begin
        step();
        if (es_a[0] === 1'b1) pulses++;
      end
      chk($sformatf("tbl%0d_pulses", v), 32'(pulses), 32'(tbl[v].pulses));
      chk($sformatf("tbl%0d_count0", v), 32'(cnt_a[7:0]), 32'(tbl[v].cnt));
    end
    chk("tbl_other_counts", 32'(cnt_a[31:8]), 32'd0);

    // 17 rising edges: wrap vs saturate on the 4-bit instances.
    mode   = 2'd0;
    enable = 1'b1;
    clear  = 4'hF;
    step();
    clear = 4'h0;
    for (int e = 0; e < 17; e++) begin
      signal[0] = 1'b1;
      step();
      step();
      signal[0] = 1'b0;
      step();
      step();
    end
    chk("w8_17_count", 32'(cnt_a[7:0]), 32'd17);
    chk("w8_17_ovf", 32'(ovf_a[0]), 32'd0);
    chk("w4wrap_17_count", 32'(cnt_b[3:0]), 32'd1);
    chk("w4wrap_17_ovf", 32'(ovf_b[0]), 32'd1);
    chk("w4sat_17_count", 32'(cnt_c[3:0]), 32'd15);
    chk("w4sat_17_ovf", 32'(ovf_c[0]), 32'd1);
    clear[0] = 1'b1;
    step();
    clear = 4'h0;
    chk("clr_count_b", 32'(cnt_b[3:0]), 32'd0);
    chk("clr_ovf_b", 32'(ovf_b[0]), 32'd0);
    chk("clr_count_c", 32'(cnt_c[3:0]), 32'd0);
    chk("clr_ovf_c", 32'(ovf_c[0]), 32'd0);

    // Exact latency: pulse only after the third edge following the change.
    signal[0] = 1'b1;
    step();
    chk("lat_edge1", 32'(es_a[0]), 32'd0);
    step();
    chk("lat_edge2", 32'(es_a[0]), 32'd0);
    step();
    chk("lat_edge3", 32'(es_a[0]), 32'd1);
    chk("lat_count3", 32'(cnt_a[7:0]), 32'd1);
    step();
    chk("lat_edge4", 32'(es_a[0]), 32'd0);
    signal[0] = 1'b0;
    repeat (3) step();

    // Clear on the same edge as a detected edge on ch1.
    signal[1] = 1'b1;
    repeat (3) step();
    signal[1] = 1'b0;
    repeat (3) step();
    chk("ch1_pre_count", 32'(cnt_a[15:8]), 32'd1);
    signal[1] = 1'b1;
    step();
    step();
    clear[1] = 1'b1;
    step();
    clear = 4'h0;
    chk("clr_edge_pulse", 32'(es_a[1]), 32'd1);
    chk("clr_edge_count", 32'(cnt_a[15:8]), 32'd0);
    step();
    chk("clr_edge_after", 32'(cnt_a[15:8]), 32'd0);

    // Snapshot coinciding with an increment from 5 to 6.
    clear[0] = 1'b1;
    step();
    clear = 4'h0;
    for (int e = 0; e < 5; e++) begin
      signal[0] = 1'b1;
      step();
      step();
      signal[0] = 1'b0;
      step();
      step();
    end
    signal[0] = 1'b1;
    step();
    step();
    snap = 1'b1;
    step();
    snap = 1'b0;
    chk("snap_inc_snapcnt", 32'(snc_a[7:0]), 32'd5);
    chk("snap_inc_count", 32'(cnt_a[7:0]), 32'd6);
    chk("snap_inc_valid", 32'(sv_a), 32'd1);
    step();
    chk("snap_inc_valid_next", 32'(sv_a), 32'd0);
    snap = 1'b1;
    step();
    chk("snap_b2b_1", 32'(sv_a), 32'd1);
    step();
    chk("snap_b2b_2", 32'(sv_a), 32'd1);
    snap = 1'b0;
    step();
    chk("snap_b2b_end", 32'(sv_a), 32'd0);
    chk("snap_b2b_val", 32'(snc_a[7:0]), 32'd6);

    // Asynchronous reset mid-count with inputs toggling.
    signal = 4'hF;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_count", cnt_a, 32'd0);
    chk("async_rst_snap", snc_a, 32'd0);
    check_all();
    for (int i = 0; i < 3; i++) begin
      signal = ~signal;
      step();
    end
    signal  = 4'h0;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_release_es", 32'(es_a), 32'd0);
    end
    chk("rst_release_count", cnt_a, 32'd0);

    // Randomised traffic including occasional resets.
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) signal[b] = ~signal[b];
      end
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      enable = ($urandom_range(7) != 0);
      clear  = 4'h0;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(31) == 0) clear[b] = 1'b1;
      end
      snap = ($urandom_range(7) == 0);
      if ($urandom_range(149) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
